// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit, paced by a 16x s_tick.
// Define UART_TX_PARITY_EN to compile in the PARITY state and the even-parity bit.
module uart_tx #(
  parameter int DATA_SIZE      = 8,
  parameter int BIT_COUNT_SIZE = 3,
  parameter int SB_TICK        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [BIT_COUNT_SIZE-1:0] BIT_LAST = BIT_COUNT_SIZE'(DATA_SIZE - 1);
  localparam logic [BIT_COUNT_SIZE-1:0] BIT_ONE  = BIT_COUNT_SIZE'(1);
  localparam logic [BIT_COUNT_SIZE-1:0] BIT_ZERO = BIT_COUNT_SIZE'(0);

  function automatic logic even_parity(input logic [DATA_SIZE-1:0] word);
    return ^word;
  endfunction

  logic [2:0]                state_r, state_s;
  logic [DATA_SIZE-1:0]      shift_r, shift_s;
  logic [4:0]                sample_count_r, sample_count_s;
  logic [BIT_COUNT_SIZE-1:0] bit_count_r, bit_count_s;
  logic                      tx_r, tx_s;
  logic                      busy_r, busy_s;
  logic                      done_s;
`ifdef UART_TX_PARITY_EN
  logic                      parity_r, parity_s;
`endif

  // State and datapath registers; reset drives the line high without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      shift_r        <= {DATA_SIZE{1'b0}};
      sample_count_r <= 5'd0;
      bit_count_r    <= BIT_ZERO;
      tx_r           <= 1'b1;
      busy_r         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r       <= 1'b0;
`endif
    end else begin
      state_r        <= state_s;
      shift_r        <= shift_s;
      sample_count_r <= sample_count_s;
      bit_count_r    <= bit_count_s;
      tx_r           <= tx_s;
      busy_r         <= busy_s;
`ifdef UART_TX_PARITY_EN
      parity_r       <= parity_s;
`endif
    end
  end

  // Next-state and datapath update; tx_s always reflects the bit of the state being entered.
  always_comb begin
    state_s        = state_r;
    shift_s        = shift_r;
    sample_count_s = sample_count_r;
    bit_count_s    = bit_count_r;
    tx_s           = tx_r;
`ifdef UART_TX_PARITY_EN
    parity_s       = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        tx_s = 1'b1;
        if (tx_start) begin
          shift_s        = data_in;
          sample_count_s = 5'd0;
          bit_count_s    = BIT_ZERO;
          tx_s           = 1'b0;
          state_s        = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_s       = even_parity(data_in);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        tx_s = 1'b0;
        if (s_tick) begin
          if (sample_count_r == TICK_LAST) begin
            sample_count_s = 5'd0;
            tx_s           = shift_r[0];
            state_s        = ST_DATA;
          end else begin
            sample_count_s = sample_count_r + 5'd1;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (sample_count_r == TICK_LAST) begin
            sample_count_s = 5'd0;
            shift_s        = {1'b0, shift_r[DATA_SIZE-1:1]};
            if (bit_count_r == BIT_LAST) begin
              bit_count_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
              tx_s        = parity_r;
              state_s     = ST_PARITY;
`else
              tx_s        = 1'b1;
              state_s     = ST_STOP;
`endif
            end else begin
              bit_count_s = bit_count_r + BIT_ONE;
              tx_s        = shift_r[1];
            end
          end else begin
            sample_count_s = sample_count_r + 5'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_s = parity_r;
        if (s_tick) begin
          if (sample_count_r == TICK_LAST) begin
            sample_count_s = 5'd0;
            tx_s           = 1'b1;
            state_s        = ST_STOP;
          end else begin
            sample_count_s = sample_count_r + 5'd1;
          end
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        tx_s = 1'b1;
        if (s_tick) begin
          if (sample_count_r == STOP_LAST) begin
            sample_count_s = 5'd0;
            state_s        = ST_IDLE;
          end else begin
            sample_count_s = sample_count_r + 5'd1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Output decode: done pulse precedes the return to IDLE; busy is registered from the next state.
  always_comb begin
    done_s = 1'b0;
    busy_s = 1'b0;
    if ((state_r == ST_STOP) && s_tick && (sample_count_r == STOP_LAST)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    if (state_s != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a monitor decodes tx cycle by cycle.
module tb_uart_tx;

  localparam int SB = 16;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  uart_tx #(.DATA_SIZE(8), .BIT_COUNT_SIZE(3), .SB_TICK(SB)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
    .data_in(data_in), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  typedef struct {
    logic [7:0] data;
    int         cpb;    // clocks per bit
    int         gap;    // required idle clocks before this frame, -1 = don't care
    bit         trunc;  // frame is cut short by reset
    bit         par;    // hand-computed even parity
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   tick_div = 1;
  int   tick_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
    s_tick   = (tick_cnt == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Accept on an s_tick cycle so the start bit spans exactly 16 ticks.
  task automatic send(input logic [7:0] d);
    for (int i = 0; i < 16 && s_tick !== 1'b1; i++) step();
    tx_start = 1'b1;
    data_in  = d;
    step();
    tx_start = 1'b0;
  endtask

  // Monitor: decode each frame off tx and compare it with the scoreboard head.
  exp_t cur;
  int   idle_cnt = -1;
  int   nbits, len, wrong, busy_bad, done_bad;
  bit   aborted, post_idle = 1'b0;
  logic expb;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        idle_cnt  = -1;
        post_idle = 1'b0;
      end else if (tx !== 1'b0) begin
        if (post_idle) begin
          check("busy_after_frame", {31'd0, tx_busy}, 32'd0);
          post_idle = 1'b0;
        end
        if (idle_cnt >= 0) idle_cnt++;
      end else begin
        check("frame_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() == 0) begin
          while (tx === 1'b0 && reset_n === 1'b1) @(negedge clk);
          idle_cnt = -1;
        end else begin
          cur = sb_q.pop_front();
          if (cur.gap >= 0) check($sformatf("gap_before_%h", cur.data), idle_cnt, cur.gap);
`ifdef UART_TX_PARITY_EN
          nbits = 11;
`else
          nbits = 10;
`endif
          aborted = 1'b0; busy_bad = 0; done_bad = 0;
          for (int b = 0; b < nbits && !aborted; b++) begin
            if (b == 0) expb = 1'b0;
            else if (b <= 8) expb = cur.data[b-1];
            else if (b == nbits - 1) expb = 1'b1;
            else expb = cur.par;
            len   = (b == nbits - 1) ? (cur.cpb * SB) / 16 : cur.cpb;
            wrong = 0;
            for (int c = 0; c < len; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset_n !== 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== expb) wrong++;
              if (tx_busy !== 1'b1) busy_bad++;
              if (tx_done_tick !== ((b == nbits - 1) && (c == len - 1))) done_bad++;
            end
            if (!aborted) check($sformatf("frame_%h_bit%0d_wrong_cycles", cur.data, b), wrong, 0);
          end
          check($sformatf("frame_%h_aborted", cur.data), {31'd0, aborted}, {31'd0, cur.trunc});
          if (!aborted) begin
            check($sformatf("frame_%h_busy_low_cycles", cur.data), busy_bad, 0);
            check($sformatf("frame_%h_done_tick_errors", cur.data), done_bad, 0);
            idle_cnt  = 0;
            post_idle = 1'b1;
          end else begin
            idle_cnt = -1;
          end
        end
      end
    end
  end

  int low_cnt;

  initial begin : stimulus
    reset_n  = 1'b0;
    s_tick   = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;
    steps(5);
    reset_n = 1'b1;
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done_tick}, 32'd0);
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1) low_cnt++;
    end
    check("idle_tx_low_cycles", low_cnt, 0);

    // Single frame at one tick per clock.
    tick_div = 1;
    sb_q.push_back('{8'hA5, 16, -1, 1'b0, 1'b0});
    send(8'hA5);
    steps(200);

    // Tick every 4th clock: 64 clocks per bit.
    tick_div = 4;
    sb_q.push_back('{8'h3C, 64, -1, 1'b0, 1'b0});
    send(8'h3C);
    steps(700);

    // Back-to-back with tx_start held; 0xFF appears only while busy.
    tick_div = 1;
    steps(2);
    sb_q.push_back('{8'h01, 16, -1, 1'b0, 1'b1});
    sb_q.push_back('{8'h80, 16, 1, 1'b0, 1'b1});
    tx_start = 1'b1;
    data_in  = 8'h01;
    step();
    data_in = 8'h80;
    steps(40);
    data_in = 8'hFF;
    steps(40);
    data_in = 8'h80;
    steps(81);
    tx_start = 1'b0;
    data_in  = 8'hFF;
    steps(60);
    tx_start = 1'b1;
    steps(20);
    tx_start = 1'b0;
    steps(200);

    // Reset during data bit 3, then a clean frame.
    sb_q.push_back('{8'hC3, 16, -1, 1'b1, 1'b0});
    send(8'hC3);
    steps(70);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, tx_busy}, 32'd0);
    check("async_reset_done", {31'd0, tx_done_tick}, 32'd0);
    steps(3);
    reset_n = 1'b1;
    steps(5);
    sb_q.push_back('{8'h55, 16, -1, 1'b0, 1'b0});
    send(8'h55);
    steps(200);

`ifdef UART_TX_PARITY_EN
    sb_q.push_back('{8'h07, 16, -1, 1'b0, 1'b1});
    send(8'h07);
    steps(200);
    sb_q.push_back('{8'h03, 16, -1, 1'b0, 1'b0});
    send(8'h03);
    steps(200);
`endif

    check("scoreboard_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
